vdic_dut_arbiter: RTL and testbench
===================================

Name: vdic_dut_arbiter

Overview:
- Shares one multi-operand ALU DUT between two requesters using round-robin arbitration.
- Each requester streams one frame: a command word, then 1..MAX_OPS operand words.
- The arbiter forwards the granted frame to the ALU serial input and waits for the ALU result window.
- It captures {data1,data2}, then returns a tagged 16-bit response, with timeout and protocol-error reporting.

Parameters:
MAX_OPS, 9, maximum operand words per frame (excluding command word)
TIMEOUT, 255, max cycles in WAIT before alu_dout_valid first rises

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  2  per-requester word valid, bit i = requester i
req_data  in  18  requester i word at [9i+8:9i]; bit 8 = 1 command word (low byte = cmd code), 0 = operand
req_last  in  2  marks last word of frame
req_ready  out  2  word accepted when valid & ready, only the granted bit may be 1
alu_din  out  9  word to ALU, same encoding as req_data
alu_din_valid  out  1  alu_din qualifier
alu_dout_valid  in  1  ALU result window
alu_data1  in  8  result high byte
alu_data2  in  8  result low byte
rsp_valid  out  1  one-cycle response strobe
rsp_id  out  1  requester served
rsp_result  out  16  {data1,data2}, 0 on error/timeout
rsp_timeout  out  1  ALU never responded
rsp_err  out  1  frame protocol error

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; counters 0; last_grant=1, so requester 0 wins first arbitration.
- IDLE:
  - If exactly one req_valid is set, grant it.
  - If both are set, grant the one not equal to last_grant.
  - Grant is registered; go to FWD next cycle. req_ready stays 0 in IDLE.
- FWD:
  - req_ready[g]=1 continuously.
  - Each accepted word is registered onto alu_din with alu_din_valid=1 the following cycle (1-cycle latency). alu_din_valid=0 in cycles with no accept.
  - Word count w starts at 0.
  - Error: w=0 word with bit8=0, or w>0 word with bit8=1, or w=MAX_OPS+1 accepted without last.
  - On error, set err flag and forward nothing further, including the offending word. Stay in FWD with ready=1, draining until req_last; then go to RESP.
  - On an error frame, the words already forwarded are left to the ALU; the arbiter does not wait for the ALU.
  - A command word with last (zero operands) is an error.
  - On accepted last with no error, go to WAIT.
- WAIT:
  - req_ready=0; timeout counter t counts each cycle.
  - While alu_dout_valid=1, capture {alu_data1,alu_data2} every cycle.
  - The first cycle alu_dout_valid=0 after having seen it 1 goes to RESP with the last captured value.
  - If t reaches TIMEOUT before alu_dout_valid is ever seen high, go to RESP with timeout=1 and result 0.
  - A dout_valid already high on WAIT entry counts as seen.
- RESP:
  - rsp_valid=1 for exactly one cycle, with rsp_id=g and fields held stable that cycle.
  - last_grant<=g; go to IDLE; counters cleared.
  - rsp_* other than rsp_valid hold their values until the next RESP.
- No new grant in the RESP cycle; minimum gap between frames is 2 idle cycles (RESP plus IDLE).
- alu_dout_valid outside WAIT is ignored.
- req_valid of the non-granted requester is ignored; it must hold until granted.
- Frame arriving simultaneously with RESP waits for IDLE.

Test Plan:
- Req0 only: cmd ADD, operands 3,4,5 (last on 5) -> alu_din sequence 0x1xx(ADD),3,4,5 one cycle after each accept. ALU model returns 12 -> rsp_valid once, rsp_id=0, rsp_result=12, err=0, timeout=0.
- Both requesters valid from reset, each SUB 10,3 -> req0 served first (rsp_id=0, 7), then req1 (rsp_id=1, 7). Repeat simultaneously -> order alternates 0,1,0,1.
- Req1 frame starting with operand word 0x005 -> nothing forwarded, frame drained, rsp_err=1, rsp_result=0, rsp_id=1.
- Frame of 10 operands with MAX_OPS=9 -> 9 operands forwarded, 10th dropped, rsp_err=1 after last.
- ALU model silent -> rsp_timeout=1 exactly TIMEOUT cycles after WAIT entry, result 0. ALU answering at t=TIMEOUT-1 -> no timeout.
- Assert rst_n low mid-FWD with 2 of 4 words sent -> all outputs 0 immediately. After release, requester 0 granted first and the new frame completes correctly.

Source files
------------

// File: rtl/vdic_dut_arbiter.sv
// Round-robin arbiter sharing one serial multi-operand ALU between two requesters.
// Forwards one granted frame, waits for the ALU result window and returns a tagged response.
module vdic_dut_arbiter #(
  parameter int MAX_OPS = 9,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  input  logic [17:0] req_data,
  input  logic [1:0]  req_last,
  output logic [1:0]  req_ready,
  output logic [8:0]  alu_din,
  output logic        alu_din_valid,
  input  logic        alu_dout_valid,
  input  logic [7:0]  alu_data1,
  input  logic [7:0]  alu_data2,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [15:0] rsp_result,
  output logic        rsp_timeout,
  output logic        rsp_err
);
  localparam int WW = $clog2(MAX_OPS + 2);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] W_FULL = WW'(MAX_OPS + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, FWD, WAIT, RESP} state_t;

  state_t          state;
  logic            g, last_grant, err, seen;
  logic [WW-1:0]   w;
  logic [TW-1:0]   t;
  logic [15:0]     cap;
  logic [1:0][8:0] req_word;
  logic [8:0]      word;
  logic            acc, lst, bad;

  assign req_word  = req_data;
  assign word      = req_word[g];
  assign lst       = req_last[g];
  assign acc       = (state == FWD) && req_valid[g];
  assign req_ready = (state == FWD) ? (g ? 2'b10 : 2'b01) : 2'b00;

  // First word must be a command with at least one operand to follow; later words
  // must be operands, and a word arriving once MAX_OPS operands are in is one too many.
  always_comb begin
    bad = 1'b0;
    if (w == '0) bad = !word[8] || lst;
    else         bad = word[8] || (w == W_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      g             <= 1'b0;
      last_grant    <= 1'b1;
      err           <= 1'b0;
      seen          <= 1'b0;
      w             <= '0;
      t             <= '0;
      cap           <= '0;
      alu_din       <= '0;
      alu_din_valid <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_id        <= 1'b0;
      rsp_result    <= '0;
      rsp_timeout   <= 1'b0;
      rsp_err       <= 1'b0;
    end else begin
      alu_din_valid <= 1'b0;
      rsp_valid     <= 1'b0;
      case (state)
        IDLE: if (|req_valid) begin
          g     <= (req_valid == 2'b11) ? ~last_grant : req_valid[1];
          state <= FWD;
        end
        FWD: if (acc) begin
          if (!err && !bad) begin
            alu_din       <= word;
            alu_din_valid <= 1'b1;
          end
          if (w != W_FULL) w <= w + 1'b1;
          err <= err | bad;
          if (lst) begin
            // An errored frame is answered immediately; the ALU is left to itself.
            if (err | bad) begin
              state       <= RESP;
              rsp_valid   <= 1'b1;
              rsp_id      <= g;
              rsp_result  <= '0;
              rsp_timeout <= 1'b0;
              rsp_err     <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          t <= t + 1'b1;
          if (alu_dout_valid) begin
            cap  <= {alu_data1, alu_data2};
            seen <= 1'b1;
          end else if (seen) begin
            state       <= RESP;
            rsp_valid   <= 1'b1;
            rsp_id      <= g;
            rsp_result  <= cap;
            rsp_timeout <= 1'b0;
            rsp_err     <= 1'b0;
          end else if (t == T_LAST) begin
            state       <= RESP;
            rsp_valid   <= 1'b1;
            rsp_id      <= g;
            rsp_result  <= '0;
            rsp_timeout <= 1'b1;
            rsp_err     <= 1'b0;
          end
        end
        RESP: begin
          last_grant <= g;
          w          <= '0;
          t          <= '0;
          err        <= 1'b0;
          seen       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vdic_dut_arbiter.sv
// Bench for vdic_dut_arbiter: table of frames with expected responses, a behavioural
// ALU, and scoreboards for forwarded words and tagged responses.
module tb_vdic_dut_arbiter;
  localparam int MAX_OPS = 9;
  localparam int TIMEOUT = 255;
  localparam int NV = 14;
  localparam logic [8:0] Z = 9'h000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [17:0] req_data = '0;
  logic [1:0]  req_last = '0;
  logic [1:0]  req_ready;
  logic [8:0]  alu_din;
  logic        alu_din_valid;
  logic        alu_dout_valid;
  logic [7:0]  alu_data1, alu_data2;
  logic        rsp_valid, rsp_id, rsp_timeout, rsp_err;
  logic [15:0] rsp_result;

  vdic_dut_arbiter #(.MAX_OPS(MAX_OPS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .alu_din(alu_din), .alu_din_valid(alu_din_valid),
    .alu_dout_valid(alu_dout_valid), .alu_data1(alu_data1), .alu_data2(alu_data2),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_timeout(rsp_timeout), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef logic [8:0] words_t [12];
  typedef struct {
    int grp; logic id; int n; int nfwd;
    logic err; logic to; logic [15:0] res;
    int lat; bit silent; int exp_lat;
  } vec_t;
  typedef struct { logic id; logic [15:0] res; logic err; logic to; int exp_lat; int v; } rsp_t;
  typedef struct { logic [8:0] w; int c; } fwd_t;

  vec_t   tbl [NV];
  words_t wds [NV];
  rsp_t   rsp_q [$];
  fwd_t   fwd_q [$];
  int     vectors = 0, miscompares = 0;
  int     last_acc [2];
  int     alu_lat = 1;
  bit     alu_silent = 1'b0;

  // Behavioural ALU: 0x101 = ADD, 0x102 = SUB (first operand minus the rest).
  // Answers after each forwarded burst; the window shows a stale value first.
  initial begin
    logic [15:0] acc;
    logic [7:0]  op;
    bit inb, first;
    alu_dout_valid = 1'b0; alu_data1 = '0; alu_data2 = '0;
    acc = '0; op = '0; inb = 1'b0; first = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (alu_din_valid) begin
        inb = 1'b1;
        if (alu_din[8]) begin op = alu_din[7:0]; acc = '0; first = 1'b1; end
        else if (first) begin acc = {8'h00, alu_din[7:0]}; first = 1'b0; end
        else if (op == 8'h02) acc = acc - {8'h00, alu_din[7:0]};
        else acc = acc + {8'h00, alu_din[7:0]};
      end else if (inb) begin
        inb = 1'b0;
        if (!alu_silent) begin
          repeat (alu_lat) begin @(posedge clk); #1; end
          alu_dout_valid = 1'b1;
          {alu_data1, alu_data2} = acc + 16'd1;
          @(posedge clk); #1;
          {alu_data1, alu_data2} = acc;
          @(posedge clk); #1;
          alu_dout_valid = 1'b0;
          {alu_data1, alu_data2} = '0;
        end
      end
    end
  end

  always @(negedge clk) begin
    fwd_t f;
    if (rst_n && alu_din_valid) begin
      vectors++;
      if (fwd_q.size() == 0) begin
        miscompares++;
        $display("FAIL fwd_extra: alu_din=%h forwarded, no word expected", alu_din);
      end else begin
        f = fwd_q.pop_front();
        if (alu_din !== f.w || cyc != f.c + 1) begin
          miscompares++;
          $display("FAIL fwd_word: alu_din=%h at cycle %0d, expected %h at cycle %0d",
                   alu_din, cyc, f.w, f.c + 1);
        end
      end
    end
    if (req_ready == 2'b11) begin
      miscompares++;
      $display("FAIL ready_onehot: req_ready=%b, expected at most one bit", req_ready);
    end
  end

  always @(negedge clk) begin
    rsp_t e;
    int lat;
    if (rst_n && rsp_valid) begin
      vectors++;
      if (rsp_q.size() == 0) begin
        miscompares++;
        $display("FAIL rsp_extra: id=%0d result=%h err=%b to=%b, no response expected",
                 rsp_id, rsp_result, rsp_err, rsp_timeout);
      end else begin
        e = rsp_q.pop_front();
        lat = cyc - last_acc[e.id];
        if (rsp_id !== e.id || rsp_result !== e.res || rsp_err !== e.err ||
            rsp_timeout !== e.to || (e.exp_lat >= 0 && lat != e.exp_lat)) begin
          miscompares++;
          $display("FAIL rsp_v%0d: got id=%0d result=%h err=%b to=%b lat=%0d, expected id=%0d result=%h err=%b to=%b lat=%0d",
                   e.v, rsp_id, rsp_result, rsp_err, rsp_timeout, lat,
                   e.id, e.res, e.err, e.to, e.exp_lat);
        end
      end
    end
  end

  task automatic chk_zero(input string name);
    logic [31:0] o;
    o = {req_ready, alu_din, alu_din_valid, rsp_valid, rsp_id, rsp_result, rsp_timeout, rsp_err};
    vectors++;
    if (o !== '0) begin
      miscompares++;
      $display("FAIL %s: outputs=%h, expected all zero", name, o);
    end
  endtask

  task automatic drive_frame(input int v, input int nsend);
    int id, guard;
    id = int'(tbl[v].id);
    @(posedge clk); #1;
    for (int i = 0; i < nsend; i++) begin
      req_valid[id] = 1'b1;
      req_data[9*id +: 9] = wds[v][i];
      req_last[id] = (i == tbl[v].n - 1);
      guard = 0;
      do begin @(negedge clk); guard++; end while (!req_ready[id] && guard < 3000);
      if (!req_ready[id]) begin
        vectors++; miscompares++;
        $display("FAIL accept_v%0d: word %0d never accepted, req_ready=%b", v, i, req_ready);
        break;
      end
      if (i < tbl[v].nfwd) fwd_q.push_back('{w: wds[v][i], c: cyc});
      last_acc[id] = cyc;
      @(posedge clk); #1;
    end
    req_valid[id] = 1'b0;
    req_last[id] = 1'b0;
  endtask

  task automatic push_rsp(input int v);
    rsp_q.push_back('{id: tbl[v].id, res: tbl[v].res, err: tbl[v].err, to: tbl[v].to,
                      exp_lat: tbl[v].exp_lat, v: v});
  endtask

  task automatic run_group(input int g);
    int a, b;
    a = -1; b = -1;
    for (int i = 0; i < NV; i++)
      if (tbl[i].grp == g) begin if (a < 0) a = i; else b = i; end
    alu_lat = tbl[a].lat;
    alu_silent = tbl[a].silent;
    push_rsp(a);
    if (b >= 0) push_rsp(b);
    fork
      drive_frame(a, tbl[a].n);
      if (b >= 0) drive_frame(b, tbl[b].n);
    join
    for (int k = 0; k < 2000 && rsp_q.size() != 0; k++) @(posedge clk);
    if (rsp_q.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL rsp_wait_g%0d: %0d responses outstanding, expected 0", g, rsp_q.size());
      rsp_q.delete();
    end
    repeat (8) @(posedge clk);
  endtask

  initial begin
    tbl[0]  = '{grp:0,  id:0, n:3,  nfwd:3,  err:0, to:0, res:16'd7,  lat:1,   silent:0, exp_lat:-1};
    wds[0]  = '{9'h102, 9'd10, 9'd3, Z, Z, Z, Z, Z, Z, Z, Z, Z};
    tbl[1]  = '{grp:0,  id:1, n:3,  nfwd:3,  err:0, to:0, res:16'd7,  lat:1,   silent:0, exp_lat:-1};
    wds[1]  = '{9'h102, 9'd10, 9'd3, Z, Z, Z, Z, Z, Z, Z, Z, Z};
    tbl[2]  = '{grp:1,  id:0, n:3,  nfwd:3,  err:0, to:0, res:16'd7,  lat:1,   silent:0, exp_lat:-1};
    wds[2]  = '{9'h102, 9'd10, 9'd3, Z, Z, Z, Z, Z, Z, Z, Z, Z};
    tbl[3]  = '{grp:1,  id:1, n:3,  nfwd:3,  err:0, to:0, res:16'd7,  lat:1,   silent:0, exp_lat:-1};
    wds[3]  = '{9'h102, 9'd10, 9'd3, Z, Z, Z, Z, Z, Z, Z, Z, Z};
    tbl[4]  = '{grp:2,  id:0, n:4,  nfwd:4,  err:0, to:0, res:16'd12, lat:0,   silent:0, exp_lat:5};
    wds[4]  = '{9'h101, 9'd3, 9'd4, 9'd5, Z, Z, Z, Z, Z, Z, Z, Z};
    tbl[5]  = '{grp:3,  id:1, n:2,  nfwd:0,  err:1, to:0, res:16'd0,  lat:1,   silent:0, exp_lat:-1};
    wds[5]  = '{9'h005, 9'h006, Z, Z, Z, Z, Z, Z, Z, Z, Z, Z};
    tbl[6]  = '{grp:4,  id:0, n:10, nfwd:10, err:0, to:0, res:16'd45, lat:1,   silent:0, exp_lat:-1};
    wds[6]  = '{9'h101, 9'd1, 9'd2, 9'd3, 9'd4, 9'd5, 9'd6, 9'd7, 9'd8, 9'd9, Z, Z};
    tbl[7]  = '{grp:5,  id:1, n:11, nfwd:10, err:1, to:0, res:16'd0,  lat:1,   silent:0, exp_lat:-1};
    wds[7]  = '{9'h101, 9'd1, 9'd2, 9'd3, 9'd4, 9'd5, 9'd6, 9'd7, 9'd8, 9'd9, 9'd10, Z};
    tbl[8]  = '{grp:6,  id:0, n:1,  nfwd:0,  err:1, to:0, res:16'd0,  lat:1,   silent:0, exp_lat:-1};
    wds[8]  = '{9'h101, Z, Z, Z, Z, Z, Z, Z, Z, Z, Z, Z};
    tbl[9]  = '{grp:7,  id:1, n:3,  nfwd:2,  err:1, to:0, res:16'd0,  lat:1,   silent:0, exp_lat:-1};
    wds[9]  = '{9'h102, 9'd7, 9'h101, Z, Z, Z, Z, Z, Z, Z, Z, Z};
    tbl[10] = '{grp:8,  id:1, n:3,  nfwd:3,  err:0, to:1, res:16'd0,  lat:1,   silent:1, exp_lat:TIMEOUT+1};
    wds[10] = '{9'h101, 9'd2, 9'd2, Z, Z, Z, Z, Z, Z, Z, Z, Z};
    tbl[11] = '{grp:9,  id:0, n:3,  nfwd:3,  err:0, to:0, res:16'd2,  lat:TIMEOUT-2, silent:0, exp_lat:TIMEOUT+3};
    wds[11] = '{9'h101, 9'd1, 9'd1, Z, Z, Z, Z, Z, Z, Z, Z, Z};
    tbl[12] = '{grp:10, id:0, n:4,  nfwd:4,  err:0, to:0, res:16'd6,  lat:1,   silent:0, exp_lat:-1};
    wds[12] = '{9'h101, 9'd1, 9'd2, 9'd3, Z, Z, Z, Z, Z, Z, Z, Z};
    tbl[13] = '{grp:10, id:1, n:3,  nfwd:3,  err:0, to:0, res:16'd5,  lat:1,   silent:0, exp_lat:-1};
    wds[13] = '{9'h102, 9'd9, 9'd4, Z, Z, Z, Z, Z, Z, Z, Z, Z};
    last_acc[0] = 0; last_acc[1] = 0;

    repeat (2) @(negedge clk);
    chk_zero("reset_state");
    rst_n = 1'b1;

    for (int g = 0; g < 10; g++) run_group(g);

    // Reset in the middle of a frame: two of four words out, then the arbiter is cleared.
    alu_silent = 1'b1;
    drive_frame(12, 2);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1 chk_zero("reset_mid_fwd");
    repeat (2) @(negedge clk);
    chk_zero("reset_hold");
    rst_n = 1'b1;
    run_group(10);

    vectors++;
    if (fwd_q.size() != 0) begin
      miscompares++;
      $display("FAIL fwd_leftover: %0d words never forwarded, expected 0", fwd_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
